// File: rtl/postfix_eval_engine.sv
// postfix_eval_engine: walks a postfix code stream, fetching leaves and dispatching ops to a shared FP ALU.
module postfix_eval_engine #(
  parameter int DATA_WIDTH   = 32,
  parameter int CODE_WIDTH   = 8,
  parameter int NUM_EXPR     = 4,
  parameter int OFFSET_WIDTH = 11,
  parameter int STACK_DEPTH  = 16
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [$clog2(NUM_EXPR)-1:0]              expression_index,
  output logic [$clog2(NUM_EXPR)+OFFSET_WIDTH-1:0] code_addr,
  input  logic [CODE_WIDTH-1:0]                    code_data,
  output logic                                     leaf_req,
  output logic [CODE_WIDTH-1:0]                    leaf_code,
  input  logic                                     leaf_ack,
  input  logic [DATA_WIDTH-1:0]                    leaf_value,
  output logic                                     alu_start,
  output logic [2:0]                               alu_op,
  output logic [DATA_WIDTH-1:0]                    operand_a,
  output logic [DATA_WIDTH-1:0]                    operand_b,
  input  logic                                     alu_done,
  input  logic [DATA_WIDTH-1:0]                    alu_result,
  output logic                                     busy,
  output logic                                     done,
  output logic [DATA_WIDTH-1:0]                    result,
  output logic                                     error,
  output logic [1:0]                               error_code
);
  localparam int EW = $clog2(NUM_EXPR);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, LEAF_WAIT, OP_ISSUE, OP_WAIT, FINISH} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] expr_q, expr_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [SW-1:0] sp_q, sp_d, sp_m1, sp_m2;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [1:0] err_q, err_d;
  logic [DATA_WIDTH-1:0] result_q, pend_val_q, pend_val_d, alu_val;
  logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic pend_q, pend_d, push, pop, is_end, is_op, is_sub, ok, wrap, opnd;
  assign sp_m1 = sp_q - SW'(1);
  assign sp_m2 = sp_q - SW'(2);
  assign is_end = &code_data;
  assign is_op = code_data[CODE_WIDTH-1 -: 2] == 2'b10;
  assign is_sub = code_q[2:0] == 3'b100;
  assign wrap = &offset_q;
  assign ok = err_q == 2'd0 && sp_q == SW'(1);
  assign opnd = state_q == OP_ISSUE || state_q == OP_WAIT;
  // An alu_done seen during OP_ISSUE is parked and consumed in OP_WAIT.
  assign alu_val = pend_q ? pend_val_q : alu_result;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign error = done && !ok;
  assign error_code = !done ? 2'd0 : err_q != 2'd0 ? err_q : ok ? 2'd0 : 2'd3;
  assign result = done && ok ? stack_q[0] : result_q;
  assign code_addr = {expr_q, offset_q};
  assign leaf_req = state_q == LEAF_WAIT;
  assign leaf_code = code_q;
  assign alu_start = state_q == OP_ISSUE;
  assign alu_op = !opnd ? 3'd0 : is_sub ? 3'b011 : code_q[2:0];
  assign operand_a = opnd ? stack_q[sp_m2[AW-1:0]] : '0;
  assign operand_b = opnd ? stack_q[sp_m1[AW-1:0]] ^ {is_sub, {(DATA_WIDTH-1){1'b0}}} : '0;
  always_comb begin
    state_d = state_q;
    expr_d = expr_q;
    offset_d = offset_q;
    sp_d = sp_q;
    code_d = code_q;
    err_d = err_q;
    pend_d = pend_q;
    pend_val_d = pend_val_q;
    push = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        expr_d = expression_index;
        offset_d = '0;
        sp_d = '0;
        err_d = 2'd0;
        pend_d = 1'b0;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        code_d = code_data;
        state_d = FINISH;
        if (!is_end && !is_op) begin
          state_d = sp_q == SW'(STACK_DEPTH) ? FINISH : LEAF_WAIT;
          err_d = sp_q == SW'(STACK_DEPTH) ? 2'd2 : err_q;
        end else if (!is_end) begin
          state_d = sp_q < SW'(2) || code_data[2:0] > 3'd4 ? FINISH : OP_ISSUE;
          err_d = sp_q < SW'(2) ? 2'd1 : code_data[2:0] > 3'd4 ? 2'd3 : err_q;
        end
      end
      LEAF_WAIT: if (leaf_ack) begin
        push = 1'b1;
        sp_d = sp_q + SW'(1);
        offset_d = offset_q + OFFSET_WIDTH'(1);
        state_d = wrap ? FINISH : FETCH;
        err_d = wrap ? 2'd3 : err_q;
      end
      OP_ISSUE: begin
        state_d = OP_WAIT;
        pend_d = alu_done;
        pend_val_d = alu_result;
      end
      OP_WAIT: if (alu_done || pend_q) begin
        pop = 1'b1;
        pend_d = 1'b0;
        sp_d = sp_m1;
        offset_d = offset_q + OFFSET_WIDTH'(1);
        state_d = wrap ? FINISH : FETCH;
        err_d = wrap ? 2'd3 : err_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      expr_q <= '0;
      offset_q <= '0;
      sp_q <= '0;
      code_q <= '0;
      err_q <= 2'd0;
      pend_q <= 1'b0;
      pend_val_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      expr_q <= expr_d;
      offset_q <= offset_d;
      sp_q <= sp_d;
      code_q <= code_d;
      err_q <= err_d;
      pend_q <= pend_d;
      pend_val_q <= pend_val_d;
      result_q <= result;
    end
  end
  always_ff @(posedge clock) begin
    if (push) stack_q[sp_q[AW-1:0]] <= leaf_value;
    if (pop) stack_q[sp_m2[AW-1:0]] <= alu_val;
  end
endmodule

// File: tb/tb_postfix_eval_engine.sv
// tb_postfix_eval_engine: scoreboard bench with ROM, leaf-decoder and ALU models around postfix_eval_engine.
module tb_postfix_eval_engine;
  localparam int DW = 32, CW = 8, AW = 13;
  typedef struct {logic [31:0] res; logic err; logic [1:0] code;} exp_t;
  typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b;} aexp_t;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0] expression_index = 2'd0;
  logic [AW-1:0] code_addr;
  logic [CW-1:0] code_data = '0;
  logic leaf_req, leaf_ack, alu_start, alu_done, busy, done, error;
  logic [CW-1:0] leaf_code;
  logic [DW-1:0] leaf_value, operand_a, operand_b, alu_result, result;
  logic [2:0] alu_op;
  logic [1:0] error_code;
  logic [7:0] rom [1 << AW];
  exp_t exp_q[$];
  aexp_t alu_q[$];
  int vectors = 0, miscompares = 0, done_cnt = 0, leaf_cnt = 0, alu_starts = 0;
  int leaf_lat = 0, alu_lat = 1;
  bit chk_addr = 1'b0;

  postfix_eval_engine #(.STACK_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .expression_index(expression_index),
    .code_addr(code_addr), .code_data(code_data), .leaf_req(leaf_req), .leaf_code(leaf_code),
    .leaf_ack(leaf_ack), .leaf_value(leaf_value), .alu_start(alu_start), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .done(done), .result(result), .error(error), .error_code(error_code));

  always #5 clock = ~clock;
  always @(posedge clock) code_data <= rom[code_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] leaf_fn(input logic [7:0] c);
    return c == 8'h01 ? 32'h40400000 : c == 8'h02 ? 32'h40800000 :
           c == 8'h03 ? 32'h40A00000 : c == 8'h04 ? 32'h40000000 : {24'h3F8000, c};
  endfunction

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'b011 && a == 32'h40400000 && b == 32'h40800000) return 32'h40E00000;
    if (op == 3'b011 && a == 32'h40A00000 && b == 32'hC0000000) return 32'h40400000;
    return 32'hDEADBEEF;
  endfunction

  task automatic load(input int r, input int n, input logic [47:0] v);
    for (int i = 0; i < n; i++) rom[r * 2048 + i] = v[8 * (n - 1 - i) +: 8];
  endtask

  initial begin
    int w;
    leaf_ack = 1'b0;
    leaf_value = '0;
    w = 0;
    forever begin
      @(posedge clock); #1;
      if (leaf_ack || reset || !leaf_req) begin
        leaf_ack = 1'b0;
        w = leaf_lat;
      end else if (w == 0) begin
        leaf_ack = 1'b1;
        leaf_value = leaf_fn(leaf_code);
        leaf_cnt++;
      end else w--;
    end
  end

  initial begin
    int c;
    bit p;
    logic [31:0] r, hold_b;
    aexp_t x;
    alu_done = 1'b0;
    alu_result = '0;
    p = 1'b0;
    c = 0;
    r = '0;
    hold_b = '0;
    forever begin
      @(posedge clock); #1;
      alu_done = 1'b0;
      if (reset) p = 1'b0;
      if (alu_start) begin
        alu_starts++;
        if (alu_q.size() == 0) check("unexpected_alu_start", 1, 0);
        else begin
          x = alu_q.pop_front();
          check("alu_op", {29'd0, alu_op}, {29'd0, x.op});
          check("operand_a", operand_a, x.a);
          check("operand_b", operand_b, x.b);
        end
        hold_b = operand_b;
        r = alu_fn(alu_op, operand_a, operand_b);
        p = 1'b1;
        c = alu_lat;
      end else if (p) c--;
      if (p && c == 0) begin
        alu_done = 1'b1;
        alu_result = r;
        p = 1'b0;
        if (!alu_start) check("operand_b_hold", operand_b, hold_b);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("error", {31'd0, error}, {31'd0, e.err});
          check("error_code", {30'd0, error_code}, {30'd0, e.code});
          check("busy_at_done", {31'd0, busy}, 1);
        end
      end
      if (chk_addr && busy) check("addr_expr", {30'd0, code_addr[12:11]}, 2);
    end
  end

  task automatic run(input logic [1:0] idx, input logic [31:0] res, input logic err,
                     input logic [1:0] code, input bit poke);
    int n0, t;
    exp_q.push_back('{res, err, code});
    n0 = done_cnt;
    @(posedge clock); #2;
    start = 1'b1;
    expression_index = idx;
    @(posedge clock); #2;
    start = 1'b0;
    if (poke) begin
      repeat (4) @(posedge clock);
      #2;
      start = 1'b1;
      expression_index = 2'd0;
      @(posedge clock); #2;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == n0 && t < 3000) begin
      @(posedge clock);
      t++;
    end
    repeat (3) @(posedge clock);
    #2;
    check("done_count", done_cnt - n0, 1);
    check("idle_after", {31'd0, busy}, 0);
  endtask

  initial begin
    int s0, t;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'hFF;
    load(0, 4, 48'h01_02_83_FF);
    load(1, 4, 48'h03_04_84_FF);
    load(2, 6, 48'h01_01_01_01_01_FF);
    load(3, 3, 48'h01_81_FF);
    repeat (3) @(posedge clock);
    #2;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {29'd0, error, error_code}, 0);
    check("rst_result", result, 0);
    check("rst_handshakes", {30'd0, alu_start, leaf_req}, 0);
    check("rst_code_addr", {19'd0, code_addr}, 0);
    check("rst_operand_a", operand_a, 0);
    check("rst_operand_b", operand_b, 0);
    reset = 1'b0;

    alu_q.push_back('{3'b011, 32'h40400000, 32'h40800000});
    run(2'd0, 32'h40E00000, 1'b0, 2'd0, 1'b0);

    leaf_lat = 2;
    alu_lat = 0;
    alu_q.push_back('{3'b011, 32'h40A00000, 32'hC0000000});
    run(2'd1, 32'h40400000, 1'b0, 2'd0, 1'b0);

    leaf_lat = 1;
    alu_lat = 1;
    leaf_cnt = 0;
    chk_addr = 1'b1;
    run(2'd2, 32'h40400000, 1'b1, 2'd2, 1'b1);
    chk_addr = 1'b0;
    check("overflow_leaf_count", leaf_cnt, 4);

    s0 = alu_starts;
    run(2'd3, 32'h40400000, 1'b1, 2'd1, 1'b0);
    check("underflow_no_alu", alu_starts - s0, 0);

    load(3, 3, 48'h01_02_FF);
    run(2'd3, 32'h40400000, 1'b1, 2'd3, 1'b0);
    load(3, 4, 48'h01_02_85_FF);
    s0 = alu_starts;
    run(2'd3, 32'h40400000, 1'b1, 2'd3, 1'b0);
    check("bad_opcode_no_alu", alu_starts - s0, 0);

    alu_lat = 20;
    s0 = alu_starts;
    alu_q.push_back('{3'b011, 32'h40400000, 32'h40800000});
    exp_q.push_back('{32'h40E00000, 1'b0, 2'd0});
    @(posedge clock); #2;
    start = 1'b1;
    expression_index = 2'd0;
    @(posedge clock); #2;
    start = 1'b0;
    t = 0;
    while (alu_starts == s0 && t < 500) begin
      @(posedge clock);
      t++;
    end
    check("alu_start_seen", alu_starts - s0, 1);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    s0 = done_cnt;
    exp_q.delete();
    @(posedge clock); #2;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_alu_start", {31'd0, alu_start}, 0);
    check("abort_leaf_req", {31'd0, leaf_req}, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (30) @(posedge clock);
    #2;
    check("abort_no_done", done_cnt - s0, 0);
    alu_lat = 1;
    alu_q.push_back('{3'b011, 32'h40400000, 32'h40800000});
    run(2'd0, 32'h40E00000, 1'b0, 2'd0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    check("alu_queue_empty", alu_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/postfix_eval_engine.md
Name: postfix_eval_engine

Overview:
- Parametrised postfix expression evaluator; next generation of the per-polynomial term accumulator.
- Walks a postfix code stream for one of NUM_EXPR expressions held in a synchronous code ROM.
- Obtains leaf values through a generic leaf-decoder handshake and dispatches operators to a shared floating-point ALU.
- Keeps operands in an internal register stack of configurable depth, with overflow/underflow/malformed-stream detection and a single-pulse result.

Parameters:
- DATA_WIDTH, 32, operand/result width (IEEE-754 single; sign at MSB).
- CODE_WIDTH, 8, postfix code width.
- NUM_EXPR, 4, number of selectable expressions.
- OFFSET_WIDTH, 11, address bits per expression region.
- STACK_DEPTH, 16, internal stack entries (>=2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin evaluation; sampled only in IDLE.
- expression_index  in  $clog2(NUM_EXPR)  expression select; latched on accepted start.
- code_addr  out  $clog2(NUM_EXPR)+OFFSET_WIDTH  {expr_reg, offset} to code ROM.
- code_data  in  CODE_WIDTH  ROM data, valid 1 cycle after code_addr.
- leaf_req  out  1  leaf-decode request, level.
- leaf_code  out  CODE_WIDTH  code being decoded.
- leaf_ack  in  1  leaf value valid.
- leaf_value  in  DATA_WIDTH  decoded value.
- alu_start  out  1  one-cycle ALU launch pulse.
- alu_op  out  3  000 exp, 001 mul, 010 div, 011 add.
- operand_a  out  DATA_WIDTH  left operand.
- operand_b  out  DATA_WIDTH  right operand.
- alu_done  in  1  ALU result valid.
- alu_result  in  DATA_WIDTH  ALU result.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_WIDTH  final value; held until next start.
- error  out  1  valid with done.
- error_code  out  2  0 none, 1 underflow, 2 overflow, 3 malformed.

Behaviour:
- Reset: state IDLE, sp=0, offset=0.
  - All outputs 0: busy, done, error, error_code, result, alu_start, leaf_req, code_addr, operand_a, operand_b.
  - Reset mid-evaluation aborts at once: no done pulse; leaf_req and alu_start drop the next cycle.
- Code format:
  - [CW-1:CW-2] = 00 const, 01 var/key, 11 trig -> leaf.
  - [CW-1:CW-2] = 10 -> operator; opcode = [2:0].
  - All-ones code = END; checked before class decode.
- States: IDLE, FETCH, DECODE, LEAF_WAIT, OP_ISSUE, OP_WAIT, FINISH.
- IDLE:
  - On start: latch expression_index, offset<=0, sp<=0, go to FETCH.
  - start is ignored while busy.
- FETCH: drive code_addr={expr_reg, offset}; go to DECODE.
- DECODE: code_data is valid here; latch the code, then:
  - END -> FINISH.
  - Leaf with sp==STACK_DEPTH -> FINISH, error 2.
  - Other leaf -> leaf_req=1, leaf_code=code, go to LEAF_WAIT.
  - Operator with sp<2 -> FINISH, error 1.
  - Opcode 101..111 -> FINISH, error 3.
  - Valid operator -> OP_ISSUE.
- LEAF_WAIT:
  - Hold leaf_req until leaf_ack is sampled high (same-cycle completion).
  - Then push leaf_value to stack[sp], sp+1, drop leaf_req, offset+1, go to FETCH.
- OP_ISSUE:
  - operand_a=stack[sp-2], operand_b=stack[sp-1], alu_start=1 for exactly one cycle, go to OP_WAIT.
  - Subtract (opcode 100) issues alu_op=011 with operand_b sign bit inverted.
- OP_WAIT:
  - operand_a, operand_b and alu_op stay stable until alu_done.
  - On alu_done: stack[sp-2]<=alu_result, sp-1, offset+1, go to FETCH.
  - alu_done arriving in the same cycle as alu_start is accepted in the following cycle.
- Offset wrap: incrementing past 2^OFFSET_WIDTH-1 without END -> FINISH, error 3.
- FINISH (one cycle):
  - done=1, busy still 1 in this cycle; return to IDLE.
  - No prior error and sp==1: result=stack[0], error=0.
  - No prior error and sp!=1: error=1, error_code=3, result unchanged.
  - Prior error: error=1 with the stored code, result unchanged.
- Latency, per element: leaf = 2 + leaf wait cycles; operator = 3 + ALU latency; END adds 3 (FETCH, DECODE, FINISH).

Test Plan:
- idx0 stream {00_x,00_y,10_00011,FF}; leaf values 0x40400000, 0x40800000; ALU model add -> alu_op=011, a=0x40400000, b=0x40800000; result=0x40E00000, done pulse, error=0.
- Subtract stream {leaf 5.0, leaf 2.0, 10_00100, END} -> alu_op=011, operand_b=0xC0000000; result=0x40400000.
- STACK_DEPTH=4, five leaves then END -> done with error=1, code 2; fifth leaf_req never asserted.
- Stream {leaf, op mul, END} -> error code 1, no alu_start; stream {leaf, leaf, END} -> error code 3.
- expression_index=2 -> code_addr[MSBs]=2 for every fetch; start pulsed while busy has no effect.
- Reset asserted in OP_WAIT -> busy=0, alu_start=0, leaf_req=0 next cycle, no done; a new start evaluates correctly.
